// File: rtl/regfile_rename_if.sv
// Rename/commit/operand-read bundle between the issue logic and the
// architectural register file with its rename table.
interface regfile_rename_if #(
  parameter int NREAD = 2,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
);
  logic                   rename_valid;
  logic [4:0]             rename_rd;
  logic [ROB_W-1:0]       rename_tag;
  logic                   commit_valid;
  logic [4:0]             commit_rd;
  logic [ROB_W-1:0]       commit_tag;
  logic [XLEN-1:0]        commit_val;
  logic                   flush;
  logic [NREAD*5-1:0]     rd_id;
  logic [NREAD*XLEN-1:0]  rd_val;
  logic [NREAD-1:0]       rd_has_dep;
  logic [NREAD*ROB_W-1:0] rd_dep;
  logic [NREAD*ROB_W-1:0] rob_q_tag;
  logic [NREAD-1:0]       rob_q_avail;
  logic [NREAD*XLEN-1:0]  rob_q_val;
  logic [5:0]             busy_count;

  modport master (
    output rename_valid, rename_rd, rename_tag,
    output commit_valid, commit_rd, commit_tag, commit_val,
    output flush, rd_id, rob_q_avail, rob_q_val,
    input  rd_val, rd_has_dep, rd_dep, rob_q_tag, busy_count
  );

  modport slave (
    input  rename_valid, rename_rd, rename_tag,
    input  commit_valid, commit_rd, commit_tag, commit_val,
    input  flush, rd_id, rob_q_avail, rob_q_val,
    output rd_val, rd_has_dep, rd_dep, rob_q_tag, busy_count
  );
endinterface

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename (busy/tag) state
// and bypassing operand read ports.
module regfile_rename #(
  parameter int NREAD = 2,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input logic              clk_in,
  input logic              rst_in,
  input logic              rdy_in,
  regfile_rename_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [32];
  logic [ROB_W-1:0] dep_q  [32];
  logic [31:0]      busy_q;
  logic [5:0]       cnt_q;

  logic ren;
  logic cclr;
  logic inc;

  assign ren  = bus.rename_valid && (bus.rename_rd != 5'd0) && !bus.flush;
  // A same-cycle rename of the register keeps it busy on the new tag.
  assign cclr = bus.commit_valid && (bus.commit_rd != 5'd0)
             && busy_q[bus.commit_rd]
             && (dep_q[bus.commit_rd] == bus.commit_tag)
             && !(ren && (bus.rename_rd == bus.commit_rd));
  assign inc  = ren && !busy_q[bus.rename_rd];

  logic [NREAD*XLEN-1:0]  val_c;
  logic [NREAD-1:0]       hd_c;
  logic [NREAD*ROB_W-1:0] dep_c;
  logic [4:0]             id_v;
  logic                   qa_v;
  logic [XLEN-1:0]        qv_v;

  always_comb begin
    val_c = '0;
    hd_c  = '0;
    dep_c = '0;
    id_v  = '0;
    qa_v  = 1'b0;
    qv_v  = '0;
    for (int k = 0; k < NREAD; k++) begin
      id_v = bus.rd_id[5*k +: 5];
      qa_v = bus.rob_q_avail[k];
      qv_v = bus.rob_q_val[XLEN*k +: XLEN];
      if (id_v == 5'd0) begin
        val_c[XLEN*k +: XLEN] = '0;
      end else if (bus.rename_valid && !bus.flush
                   && (bus.rename_rd == id_v)) begin
        dep_c[ROB_W*k +: ROB_W] = bus.rename_tag;
        hd_c[k]                 = !qa_v;
        val_c[XLEN*k +: XLEN]   = qv_v;
      end else if (busy_q[id_v] && bus.commit_valid
                   && (bus.commit_tag == dep_q[id_v])) begin
        dep_c[ROB_W*k +: ROB_W] = dep_q[id_v];
        val_c[XLEN*k +: XLEN]   = bus.commit_val;
      end else if (busy_q[id_v]) begin
        dep_c[ROB_W*k +: ROB_W] = dep_q[id_v];
        hd_c[k]                 = !qa_v;
        val_c[XLEN*k +: XLEN]   = qa_v ? qv_v : regs_q[id_v];
      end else begin
        dep_c[ROB_W*k +: ROB_W] = dep_q[id_v];
        val_c[XLEN*k +: XLEN]   = regs_q[id_v];
      end
    end
  end

  assign bus.rd_val     = val_c;
  assign bus.rd_has_dep = hd_c;
  assign bus.rd_dep     = dep_c;
  assign bus.rob_q_tag  = dep_c;
  assign bus.busy_count = cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        dep_q[i]  <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (rdy_in) begin
      // Retired values land even on a flush; only rename state is dropped.
      if (bus.commit_valid && (bus.commit_rd != 5'd0))
        regs_q[bus.commit_rd] <= bus.commit_val;
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) dep_q[i] <= '0;
        busy_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (cclr) busy_q[bus.commit_rd] <= 1'b0;
        if (ren) begin
          busy_q[bus.rename_rd] <= 1'b1;
          dep_q[bus.rename_rd]  <= bus.rename_tag;
        end
        if (inc && !cclr)      cnt_q <= cnt_q + 6'd1;
        else if (cclr && !inc) cnt_q <= cnt_q - 6'd1;
      end
    end
  end

endmodule
